// File: rtl/vigenere_stream_engine.sv
// vigenere_stream_engine: key entry followed by a case-preserving Vigenere encrypt/decrypt of an ASCII stream
module vigenere_stream_engine #(
  parameter int MAX_KEY_LEN = 4,
  parameter int IDX_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             char_valid,
  input  logic [7:0]       char_in,
  input  logic             mode,
  output logic [7:0]       char_out,
  output logic             out_valid,
  output logic [IDX_W:0]   key_len,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, KEY = 2'd1, RUN = 2'd2} state_t;
  state_t             state_q;
  logic               enter_q;
  logic [7:0]         key_q [MAX_KEY_LEN];
  logic [IDX_W:0]     key_len_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         char_out_q;
  logic               out_valid_q;
  logic               enter_rise;
  logic [7:0]         key_lc, key_off, base, off8, char_d;
  logic [4:0]         shift;
  logic [5:0]         sum6, wrap6;
  logic               is_up, is_lo, is_letter, idx_last;
  logic [IDX_W-1:0]   idx_d;
  assign enter_rise = enter & ~enter_q;
  assign char_out   = char_out_q;
  assign out_valid  = out_valid_q;
  assign key_len    = key_len_q;
  assign state      = state_q;
  // Cipher datapath: shift from the current key slot, applied modulo 26 within the char's own case
  always_comb begin
    key_lc    = key_q[idx_q] | 8'h20;
    key_off   = key_lc - 8'd97;
    shift     = (key_lc >= 8'd97 && key_lc <= 8'd122) ? key_off[4:0] : 5'd0;
    is_up     = char_in >= 8'd65 && char_in <= 8'd90;
    is_lo     = char_in >= 8'd97 && char_in <= 8'd122;
    is_letter = is_up | is_lo;
    base      = is_up ? 8'd65 : 8'd97;
    off8      = char_in - base;
    sum6      = mode ? {1'b0, off8[4:0]} + 6'd26 - {1'b0, shift} : {1'b0, off8[4:0]} + {1'b0, shift};
    wrap6     = sum6 >= 6'd26 ? sum6 - 6'd26 : sum6;
    char_d    = is_letter ? base + {2'b00, wrap6} : char_in;
    idx_last  = {1'b0, idx_q} == key_len_q - (IDX_W+1)'(1);
    idx_d     = idx_last ? '0 : idx_q + IDX_W'(1);
  end
  // Control FSM with key storage, key index and registered cipher output
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      enter_q     <= 1'b0;
      key_len_q   <= '0;
      idx_q       <= '0;
      char_out_q  <= 8'h20;
      out_valid_q <= 1'b0;
      for (int i = 0; i < MAX_KEY_LEN; i++) key_q[i] <= '0;
    end else begin
      enter_q     <= enter;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (enter_rise) state_q <= KEY;
        KEY: begin
          if (enter_rise) begin
            if (key_len_q != '0) state_q <= RUN;
          end else if (char_valid) begin
            key_q[key_len_q[IDX_W-1:0]] <= char_in;
            key_len_q <= key_len_q + (IDX_W+1)'(1);
            if (key_len_q == (IDX_W+1)'(MAX_KEY_LEN - 1)) state_q <= RUN;
          end
        end
        RUN: begin
          if (enter_rise) begin
            state_q   <= IDLE;
            key_len_q <= '0;
            idx_q     <= '0;
            for (int i = 0; i < MAX_KEY_LEN; i++) key_q[i] <= '0;
          end else if (char_valid) begin
            char_out_q  <= char_d;
            out_valid_q <= 1'b1;
            if (is_letter) idx_q <= idx_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vigenere_stream_engine.sv
// tb_vigenere_stream_engine: directed and randomized checks of the Vigenere engine against a modulo-26 model
module tb_vigenere_stream_engine;
  logic       clk = 1'b0, reset = 1'b0, enter = 1'b0, char_valid = 1'b0, mode = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic [7:0] char_out;
  logic       out_valid;
  logic [2:0] key_len;
  logic [1:0] state;
  int vectors = 0, miscompares = 0;

  vigenere_stream_engine #(.MAX_KEY_LEN(4), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .enter(enter), .char_valid(char_valid), .char_in(char_in),
    .mode(mode), .char_out(char_out), .out_valid(out_valid), .key_len(key_len), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int kshift(input logic [7:0] k);
    if (k >= "A" && k <= "Z") return int'(k) - 65;
    if (k >= "a" && k <= "z") return int'(k) - 97;
    return 0;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] c, input int s, input logic m);
    int b;
    if (c >= "A" && c <= "Z") b = 65;
    else if (c >= "a" && c <= "z") b = 97;
    else return c;
    return 8'(b + (int'(c) - b + (m ? 26 - s : s)) % 26);
  endfunction

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic load_key(input string k);
    press_enter();
    check("key_state", 32'(state), 32'd1);
    for (int i = 0; i < k.len(); i++) begin
      char_valid = 1'b1;
      char_in = k[i];
      tick();
    end
    char_valid = 1'b0;
    check({"key_len_", k}, 32'(key_len), 32'(k.len()));
    if (k.len() < 4) press_enter();
    check({"run_state_", k}, 32'(state), 32'd2);
  endtask

  task automatic send(input logic [7:0] c, input logic m, input logic [7:0] exp, input string tag);
    char_valid = 1'b1;
    char_in = c;
    mode = m;
    tick();
    char_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(char_out), 32'(exp));
  endtask

  task automatic run_str(input string in, input string exp, input logic m);
    for (int i = 0; i < in.len(); i++) send(in[i], m, exp[i], $sformatf("%s[%0d]", in, i));
    tick();
    check({in, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({in, "_hold"}, 32'(char_out), 32'(exp[exp.len()-1]));
  endtask

  initial begin
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_key_len", 32'(key_len), 32'd0);
    check("rst_char_out", 32'(char_out), 32'h20);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    tick();
    char_valid = 1'b1;
    char_in = "x";
    tick();
    char_valid = 1'b0;
    check("idle_ignore_valid", 32'(out_valid), 32'd0);
    check("idle_ignore_state", 32'(state), 32'd0);
    press_enter();
    check("enter_to_key", 32'(state), 32'd1);
    press_enter();
    check("empty_key_enter", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      char_valid = 1'b1;
      char_in = (i == 0) ? "K" : (i == 1) ? "E" : "Y";
      tick();
    end
    char_valid = 1'b0;
    check("key3_len", 32'(key_len), 32'd3);
    press_enter();
    check("key3_run", 32'(state), 32'd2);
    run_str("hello", "rijvs", 1'b0);
    press_enter();
    check("run_to_idle", 32'(state), 32'd0);
    check("run_to_idle_len", 32'(key_len), 32'd0);
    load_key("KEY");
    run_str("rijvs", "hello", 1'b1);
    press_enter();
    load_key("KEY");
    run_str("RIJVS", "HELLO", 1'b1);
    press_enter();
    load_key("BCDE");
    run_str("aaaaa", "bcdeb", 1'b0);
    press_enter();
    load_key("AB");
    run_str("a,a", "a,b", 1'b0);
    press_enter();
    load_key("B");
    run_str("zZ", "aA", 1'b0);
    enter = 1'b1;
    char_valid = 1'b1;
    char_in = "q";
    tick();
    enter = 1'b0;
    char_valid = 1'b0;
    check("coll_valid", 32'(out_valid), 32'd0);
    check("coll_state", 32'(state), 32'd0);
    check("coll_key_len", 32'(key_len), 32'd0);
    check("coll_hold", 32'(char_out), 32'h41);
    tick();
    load_key("KEY");
    reset = 1'b0;
    char_valid = 1'b1;
    char_in = "h";
    tick();
    reset = 1'b1;
    char_valid = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_key_len", 32'(key_len), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_char_out", 32'(char_out), 32'h20);
    for (int t = 0; t < 10; t++) begin
      string k;
      int klen, idx;
      logic [7:0] c;
      logic m;
      k = "";
      klen = $urandom_range(1, 4);
      for (int i = 0; i < klen; i++) begin
        c = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(32, 126))
          : ($urandom_range(0, 1) ? 8'(65 + $urandom_range(0, 25)) : 8'(97 + $urandom_range(0, 25)));
        k = $sformatf("%s%c", k, c);
      end
      load_key(k);
      idx = 0;
      for (int j = 0; j < 20; j++) begin
        c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(32, 126))
          : ($urandom_range(0, 1) ? 8'(65 + $urandom_range(0, 25)) : 8'(97 + $urandom_range(0, 25)));
        m = 1'($urandom_range(0, 1));
        send(c, m, model(c, kshift(k[idx]), m), $sformatf("rnd%0d_%0d", t, j));
        if ((c >= "A" && c <= "Z") || (c >= "a" && c <= "z")) idx = (idx + 1) % klen;
      end
      press_enter();
      check($sformatf("rnd%0d_idle", t), 32'(state), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
